// File: rtl/mem_stage.sv
// Pipeline memory-access stage: holds one instruction from EX, runs at most one
// data-memory transaction for loads/stores, and hands the result to WB.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_to_mem_valid,
  output logic            mem_allowin,
  input  logic [PC_W-1:0] in_pc,
  input  logic [2:0]      in_memop,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic            in_reg_wen,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            flush,
  output logic            mem_to_wb_valid,
  input  logic            wb_allowin,
  output logic [PC_W-1:0] wb_pc,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_wen,
  output logic            wb_misalign,
  output logic [XLEN-1:0] wb_result,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_wen,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            fwd_wen,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_busy,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Handshake rule for every channel here: a transfer happens on a rising edge
  // where valid & ready are both high; a request, once valid, keeps all of its
  // fields stable until that edge. The one exception is flush, which withdraws
  // a not-yet-accepted request from the following cycle on.

  logic            mem_valid;
  logic [PC_W-1:0] pc_q;
  logic [2:0]      memop_q;
  logic            memread_q;
  logic            memwrite_q;
  logic            reg_wen_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_buf;
  logic [1:0]      state;
  logic            killed;

  logic [1:0]      state_next;
  logic            killed_next;
  logic            capture;
  logic            drain_done;
  logic            flush_drop;

  logic            access;
  logic [2:0]      offset;
  logic            misalign;
  logic            ready_go;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] load_shifted;
  logic [XLEN-1:0] load_data;

  assign access = memread_q | memwrite_q;
  assign offset = alu_q[2:0];

  always_comb begin
    misalign = 1'b0;
    case (memop_q[1:0])
      2'b01:   misalign = offset[0];
      2'b10:   misalign = |offset[1:0];
      2'b11:   misalign = |offset;
      default: misalign = 1'b0;
    endcase
    misalign = misalign & access;
  end

  assign ready_go        = !access | misalign | (state == S_DONE);
  assign mem_allowin     = !mem_valid | (ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & ready_go & !killed;

  always_comb begin
    size_mask = 8'h01;
    case (memop_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    load_shifted = load_buf >> {offset, 3'b000};
    load_data    = load_shifted;
    case (memop_q)
      3'b000:  load_data = {{(XLEN-8){load_shifted[7]}},   load_shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_data = {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}},  load_shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, load_shifted[31:0]};
      default: load_data = load_shifted;
    endcase
  end

  // Once the request has been accepted the memory owes us a response, so a
  // flush from then on only marks the instruction killed and waits it out.
  always_comb begin
    state_next  = state;
    killed_next = killed;
    capture     = 1'b0;
    drain_done  = 1'b0;
    flush_drop  = 1'b0;
    case (state)
      S_IDLE: begin
        flush_drop = flush & mem_valid;
        if (mem_valid && access && !misalign && !killed && !flush)
          state_next = S_REQ;
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          state_next  = S_WAIT;
          killed_next = killed | flush;
        end else if (flush) begin
          state_next = S_IDLE;
          flush_drop = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_resp_valid) begin
          if (killed || flush) begin
            state_next  = S_IDLE;
            killed_next = 1'b0;
            drain_done  = 1'b1;
          end else begin
            state_next = S_DONE;
            capture    = 1'b1;
          end
        end else if (flush) begin
          killed_next = 1'b1;
        end
      end
      default: begin
        flush_drop = flush;
        if (flush || (ready_go && wb_allowin))
          state_next = S_IDLE;
      end
    endcase
  end

  // An EX instruction arriving in a flush cycle is discarded along with the
  // instruction held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      pc_q       <= '0;
      memop_q    <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      reg_wen_q  <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      load_buf   <= '0;
      state      <= S_IDLE;
      killed     <= 1'b0;
    end else begin
      state  <= state_next;
      killed <= killed_next;
      if (capture)
        load_buf <= dmem_rdata;
      if (mem_allowin) begin
        if (ex_to_mem_valid && !flush) begin
          mem_valid  <= 1'b1;
          pc_q       <= in_pc;
          memop_q    <= in_memop;
          memread_q  <= in_memread;
          memwrite_q <= in_memwrite;
          reg_wen_q  <= in_reg_wen;
          rd_q       <= in_rd;
          alu_q      <= in_alu_result;
          wdata_q    <= in_wdata;
        end else begin
          mem_valid <= 1'b0;
        end
      end else if (flush_drop || drain_done) begin
        mem_valid <= 1'b0;
      end
    end
  end

  assign wb_pc       = pc_q;
  assign wb_rd       = rd_q;
  assign wb_reg_wen  = reg_wen_q & !misalign;
  assign wb_misalign = misalign;
  assign wb_result   = misalign ? '0 : (memread_q ? load_data : alu_q);

  assign dmem_req_valid = (state == S_REQ);
  assign dmem_req_wen   = memwrite_q;
  assign dmem_addr      = {alu_q[XLEN-1:3], 3'b000};
  assign dmem_wdata     = wdata_q << {offset, 3'b000};
  assign dmem_wmask     = memwrite_q ? (size_mask << offset) : 8'h00;

  assign fwd_wen   = mem_valid & reg_wen_q & !killed;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wb_result;
  assign fwd_busy  = fwd_wen & memread_q & (state != S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard queues for WB results and memory
// requests, a small memory responder, and targeted stall/flush/reset cases.
module tb_mem_stage;

  localparam int XLEN = 64;
  localparam int PC_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic            clk;
  logic            rst;
  logic            ex_to_mem_valid;
  logic            mem_allowin;
  logic [PC_W-1:0] in_pc;
  logic [2:0]      in_memop;
  logic            in_memread;
  logic            in_memwrite;
  logic            in_reg_wen;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_wdata;
  logic            flush;
  logic            mem_to_wb_valid;
  logic            wb_allowin;
  logic [PC_W-1:0] wb_pc;
  logic [4:0]      wb_rd;
  logic            wb_reg_wen;
  logic            wb_misalign;
  logic [XLEN-1:0] wb_result;
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_wen;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wmask;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_rdata;
  logic            fwd_wen;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            fwd_busy;
  logic [1:0]      fsm_state;

  mem_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .in_pc(in_pc), .in_memop(in_memop), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_reg_wen(in_reg_wen), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_wdata(in_wdata), .flush(flush),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
    .wb_misalign(wb_misalign), .wb_result(wb_result),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_wen(dmem_req_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_busy(fwd_busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  // wb entry: {pc[102:71], rd[70:66], reg_wen[65], misalign[64], result[63:0]}
  logic [102:0] exp_wb_q[$];
  // req entry: {wen[136], addr[135:72], wdata[71:8], mask[7:0]}
  logic [136:0] exp_req_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // memory responder knobs
  int              ready_stall = 0;
  int              resp_lat    = 1;
  int              pend        = 0;
  logic [XLEN-1:0] mem_data    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_wb(input logic [PC_W-1:0] pc, input logic [4:0] rd, input logic wen,
                         input logic mis, input logic [XLEN-1:0] res);
    exp_wb_q.push_back({pc, rd, wen, mis, res});
  endtask

  task automatic push_req(input logic wen, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] wdata, input logic [7:0] mask);
    exp_req_q.push_back({wen, addr, wdata, mask});
  endtask

  // ---------------- memory responder ----------------
  initial begin
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_rdata      = '0;
    forever begin
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_rdata      = mem_data;
        end
      end
      if (dmem_req_valid && ready_stall > 0) begin
        dmem_req_ready = 1'b0;
        ready_stall--;
      end else if (dmem_req_valid) begin
        dmem_req_ready = 1'b1;
        pend = resp_lat;
      end else begin
        dmem_req_ready = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [102:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_to_wb_valid) begin
        if (exp_wb_q.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: got pc %h result %h expected no WB output", wb_pc, wb_result);
        end else begin
          e = exp_wb_q[0];
          check("wb_result",   wb_result,   e[63:0]);
          check("wb_misalign", 64'(wb_misalign), 64'(e[64]));
          check("wb_reg_wen",  64'(wb_reg_wen),  64'(e[65]));
          check("wb_rd",       64'(wb_rd),       64'(e[70:66]));
          check("wb_pc",       64'(wb_pc),       64'(e[102:71]));
          if (wb_allowin) void'(exp_wb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [136:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dmem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_unexpected: got addr %h wen %b expected no request", dmem_addr, dmem_req_wen);
        end else begin
          e = exp_req_q[0];
          check("req_wen",   64'(dmem_req_wen), 64'(e[136]));
          check("req_addr",  dmem_addr,  e[135:72]);
          check("req_wdata", dmem_wdata, e[71:8]);
          check("req_wmask", 64'(dmem_wmask), 64'(e[7:0]));
          if (dmem_req_ready) void'(exp_req_q.pop_front());
          else begin
            check("stall_allowin", 64'(mem_allowin), 64'd0);
            check("stall_state",   64'(fsm_state),   64'(S_REQ));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called away from the clock edge; returns at the negedge after acceptance.
  task automatic issue(input logic [PC_W-1:0] pc, input logic [2:0] memop, input logic rd_en,
                       input logic wr_en, input logic reg_wen, input logic [4:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] wdata,
                       output int waited);
    ex_to_mem_valid = 1'b1;
    in_pc = pc; in_memop = memop; in_memread = rd_en; in_memwrite = wr_en;
    in_reg_wen = reg_wen; in_rd = rd; in_alu_result = alu; in_wdata = wdata;
    waited = 0;
    #1;
    while (!mem_allowin && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!mem_allowin) begin
      n_checks++;
      $display("FAIL issue_timeout: got mem_allowin 0 after %0d cycles expected 1", waited);
    end
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n = 0;
    while (fsm_state !== s && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (fsm_state !== s) begin
      n_checks++;
      $display("FAIL %s: got state %0d expected %0d", name, fsm_state, s);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_wb_q.size() != 0 || exp_req_q.size() != 0) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_wb_q.size() != 0 || exp_req_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got %0d wb / %0d req outstanding expected 0",
               name, exp_wb_q.size(), exp_req_q.size());
      exp_wb_q.delete();
      exp_req_q.delete();
    end
  endtask

  int pc_ctr = 32'h1000;

  task automatic run_mem(input logic [2:0] memop, input logic is_store, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata,
                         input logic [XLEN-1:0] exp_wdata, input logic [7:0] exp_mask,
                         input logic [XLEN-1:0] exp_res, input logic exp_mis);
    int w;
    logic [PC_W-1:0] pc;
    pc = PC_W'(pc_ctr);
    pc_ctr += 4;
    push_wb(pc, 5'd10, !is_store && !exp_mis, exp_mis, exp_res);
    if (!exp_mis) push_req(is_store, {addr[XLEN-1:3], 3'b000}, exp_wdata, exp_mask);
    mem_data = rdata;
    issue(pc, memop, !is_store, is_store, !is_store, 5'd10, addr, wdata, w);
    wait_drain("drain");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n;
    rst = 1'b1; flush = 1'b0; wb_allowin = 1'b1; ex_to_mem_valid = 1'b0;
    in_pc = '0; in_memop = '0; in_memread = 0; in_memwrite = 0; in_reg_wen = 0;
    in_rd = '0; in_alu_result = '0; in_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_allowin",  64'(mem_allowin),     64'd1);
    check("rst_wb_valid", 64'(mem_to_wb_valid), 64'd0);
    check("rst_req",      64'(dmem_req_valid),  64'd0);
    check("rst_result",   wb_result,            64'd0);
    check("rst_fwd_wen",  64'(fwd_wen),         64'd0);
    check("rst_state",    64'(fsm_state),       64'(S_IDLE));

    // lb, sign-extended, with minimal-latency check
    push_wb(32'h100, 5'd5, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFF80);
    push_req(1'b0, 64'h80000000, 64'h0, 8'h00);
    mem_data = 64'h00000000_80FF0000;
    issue(32'h100, 3'b000, 1'b1, 1'b0, 1'b1, 5'd5, 64'h80000003, 64'h0, w);
    n = 1;
    #1;
    while (!mem_to_wb_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("lb_latency", 64'(n), 64'd4);
    wait_drain("lb_drain");

    // load extraction variants
    run_mem(3'b101, 1'b0, 64'h80000006, 64'h0, 64'hBEEF0000_00000000, 64'h0, 8'h00, 64'h00000000_0000BEEF, 1'b0);
    run_mem(3'b001, 1'b0, 64'h80000006, 64'h0, 64'hBEEF0000_00000000, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFBEEF, 1'b0);
    run_mem(3'b010, 1'b0, 64'h80000004, 64'h0, 64'h89ABCDEF_00000000, 64'h0, 8'h00, 64'hFFFFFFFF_89ABCDEF, 1'b0);
    run_mem(3'b110, 1'b0, 64'h80000004, 64'h0, 64'h89ABCDEF_00000000, 64'h0, 8'h00, 64'h00000000_89ABCDEF, 1'b0);
    run_mem(3'b100, 1'b0, 64'h80000001, 64'h0, 64'h00000000_0000F100, 64'h0, 8'h00, 64'h00000000_000000F1, 1'b0);
    run_mem(3'b011, 1'b0, 64'h80000008, 64'h0, 64'h01234567_89ABCDEF, 64'h0, 8'h00, 64'h01234567_89ABCDEF, 1'b0);

    // sw with request stalled three cycles
    ready_stall = 3;
    run_mem(3'b010, 1'b1, 64'h80000004, 64'h11223344, 64'h0, 64'h11223344_00000000, 8'hF0, 64'h80000004, 1'b0);
    // other store lanes
    run_mem(3'b000, 1'b1, 64'h80000005, 64'hAB, 64'h0, 64'h0000AB00_00000000, 8'h20, 64'h80000005, 1'b0);
    run_mem(3'b001, 1'b1, 64'h80000002, 64'hCAFE, 64'h0, 64'h00000000_CAFE0000, 8'h0C, 64'h80000002, 1'b0);
    run_mem(3'b011, 1'b1, 64'h80000008, 64'h01020304_05060708, 64'h0, 64'h01020304_05060708, 8'hFF, 64'h80000008, 1'b0);

    // misaligned accesses: no request, zero result, no register write
    run_mem(3'b010, 1'b0, 64'h80000002, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 1'b1);
    run_mem(3'b001, 1'b1, 64'h80000001, 64'h55, 64'h0, 64'h0, 8'h00, 64'h0, 1'b1);
    run_mem(3'b011, 1'b0, 64'h80000004, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 1'b1);

    // non-memory op: visible the cycle after acceptance, forwarded
    push_wb(32'h200, 5'd3, 1'b1, 1'b0, 64'h1234);
    issue(32'h200, 3'b000, 1'b0, 1'b0, 1'b1, 5'd3, 64'h1234, 64'h0, w);
    #1;
    check("alu_wb_valid", 64'(mem_to_wb_valid), 64'd1);
    check("alu_fwd_wen",  64'(fwd_wen),  64'd1);
    check("alu_fwd_rd",   64'(fwd_rd),   64'd3);
    check("alu_fwd_data", fwd_data,      64'h1234);
    check("alu_fwd_busy", 64'(fwd_busy), 64'd0);
    wait_drain("alu_drain");

    // WB back-pressure in DONE, then an ADD accepted as WB frees up
    wb_allowin = 1'b0;
    push_wb(32'h300, 5'd8, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D);
    push_req(1'b0, 64'h80000018, 64'h0, 8'h00);
    mem_data = 64'hDEADBEEF_CAFEF00D;
    issue(32'h300, 3'b011, 1'b1, 1'b0, 1'b1, 5'd8, 64'h80000018, 64'h0, w);
    #1;
    check("ld_fwd_busy", 64'(fwd_busy), 64'd1);
    wait_state(S_DONE, "ld_reach_done");
    repeat (2) begin
      @(negedge clk);
      #1;
      check("hold_allowin", 64'(mem_allowin),     64'd0);
      check("hold_valid",   64'(mem_to_wb_valid), 64'd1);
      check("hold_busy",    64'(fwd_busy),        64'd0);
      check("hold_fwd",     fwd_data, 64'hDEADBEEF_CAFEF00D);
    end
    push_wb(32'h304, 5'd4, 1'b1, 1'b0, 64'h55);
    wb_allowin = 1'b1;
    issue(32'h304, 3'b000, 1'b0, 1'b0, 1'b1, 5'd4, 64'h55, 64'h0, w);
    check("add_accept_wait", 64'(w), 64'd0);
    #1;
    check("add_wb_valid", 64'(mem_to_wb_valid), 64'd1);
    wait_drain("backpressure_drain");

    // flush while waiting for the response: drained, never reaches WB
    resp_lat = 3;
    push_req(1'b0, 64'h80000010, 64'h0, 8'h00);
    issue(32'h400, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9, 64'h80000010, 64'h0, w);
    wait_state(S_WAIT, "flush_reach_wait");
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    check("kill_allowin", 64'(mem_allowin),     64'd0);
    check("kill_fwd_wen", 64'(fwd_wen),         64'd0);
    check("kill_state",   64'(fsm_state),       64'(S_WAIT));
    repeat (2) @(negedge clk);
    #1;
    check("drain_state",   64'(fsm_state),   64'(S_IDLE));
    check("drain_allowin", 64'(mem_allowin), 64'd1);
    wait_drain("flush_drain");

    // reset mid-transaction; the late response must be ignored
    push_req(1'b0, 64'h80000020, 64'h0, 8'h00);
    issue(32'h500, 3'b011, 1'b1, 1'b0, 1'b1, 5'd11, 64'h80000020, 64'h0, w);
    wait_state(S_WAIT, "rst_reach_wait");
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("midrst_state",   64'(fsm_state),       64'(S_IDLE));
    check("midrst_valid",   64'(mem_to_wb_valid), 64'd0);
    check("midrst_allowin", 64'(mem_allowin),     64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("late_resp_state", 64'(fsm_state),       64'(S_IDLE));
    check("late_resp_valid", 64'(mem_to_wb_valid), 64'd0);
    resp_lat = 1;

    wait_drain("final_drain");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory-access stage directly downstream of the execute stage; upstream of writeback.
- Accepts one instruction per handshake from EX and issues at most one data-memory request per load/store over a valid/ready request channel with a separate response channel.
- Performs store byte-lane alignment and load extraction with sign/zero extension.
- Passes non-memory results through with zero added latency beyond the stage register, and exposes a forwarding port to decode.

Parameters:
- XLEN, 64, data/address width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ex_to_mem_valid  in  1  EX holds a valid instruction.
- mem_allowin  out  1  stage can accept from EX this cycle.
- in_pc  in  PC_W  instruction PC.
- in_memop  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- in_memread  in  1  load.
- in_memwrite  in  1  store.
- in_reg_wen  in  1  writes rd.
- in_rd  in  5  destination register.
- in_alu_result  in  XLEN  address for loads/stores, else the result.
- in_wdata  in  XLEN  store data (low bytes significant).
- flush  in  1  kill the instruction held in this stage.
- mem_to_wb_valid  out  1  valid to WB.
- wb_allowin  in  1  WB accepts.
- wb_pc  out  PC_W  PC forwarded to WB.
- wb_rd  out  5  destination register to WB.
- wb_reg_wen  out  1  register write enable to WB.
- wb_misalign  out  1  misaligned-access flag to WB.
- wb_result  out  XLEN  result to WB.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_wen  out  1  request is a write.
- dmem_addr  out  XLEN  8-byte-aligned address (in_alu_result with bits [2:0] cleared).
- dmem_wdata  out  XLEN  write data.
- dmem_wmask  out  8  write byte mask.
- dmem_resp_valid  in  1  read data / write acknowledge.
- dmem_rdata  in  XLEN  read data.
- fwd_wen  out  1  forwarding write enable.
- fwd_rd  out  5  forwarding destination register.
- fwd_data  out  XLEN  forwarding data.
- fwd_busy  out  1  load in stage whose data is not yet available.

Behaviour:
- Reset: mem_valid=0; state IDLE; all outputs 0; mem_allowin=1.
- Pipeline register:
  - mem_allowin = !mem_valid | (ready_go & wb_allowin).
  - On ex_to_mem_valid & mem_allowin, latch all in_* fields; mem_valid<=1.
  - On mem_allowin without an incoming instruction, mem_valid<=0.
- ready_go:
  - 1 for non-memory instructions and misaligned accesses.
  - Otherwise 1 only in state DONE.
- mem_to_wb_valid = mem_valid & ready_go & !killed.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: mem_valid, access, aligned, not killed -> REQ.
  - REQ: dmem_req_valid=1, all request fields held stable until dmem_req_ready. On handshake -> WAIT.
  - WAIT: on dmem_resp_valid, capture dmem_rdata into the load buffer -> DONE. The response is never accepted in the handshake cycle.
  - DONE: hold the buffered data. When the instruction leaves (wb_allowin) or is dropped, -> IDLE. An instruction accepted in the same cycle enters IDLE and is evaluated next cycle.
- Latency:
  - Memory op: at minimum, the accept cycle plus the REQ and WAIT cycles, then DONE.
  - Non-memory op: visible to WB the cycle after acceptance.
- Store lane alignment, with o = addr[2:0]:
  - size mask: b=0x01, h=0x03, w=0x0F, d=0xFF.
  - dmem_wmask = (size mask << o), truncated to 8 bits.
  - dmem_wdata = in_wdata << (8*o).
- Load extraction: shift buffered data right by 8*o, then extend per memop (b/h/w sign-extend; bu/hu/wu zero-extend; d unchanged).
- wb_result = extracted load data for loads; in_alu_result otherwise (stores included).
- Misaligned access: h with o[0]!=0; w with o[1:0]!=0; d with o!=0.
  - No request is issued; wb_misalign=1; wb_result=0.
  - wb_reg_wen forced to 0.
- Flush:
  - In IDLE/DONE: mem_valid<=0 immediately.
  - In REQ before handshake: drop the request (valid deasserts), mem_valid<=0.
  - In REQ after handshake, or in WAIT: set killed, drain the response, then mem_valid<=0. mem_to_wb_valid is never asserted for the killed instruction. mem_allowin stays 0 until the drain completes.
- Forwarding:
  - fwd_wen = mem_valid & in_reg_wen & !killed.
  - fwd_busy = fwd_wen & memread & state!=DONE.
  - fwd_data = wb_result.
- Reset mid-transaction: state IDLE and mem_valid 0 next cycle. Any late dmem_resp_valid while in IDLE is ignored.

Test Plan:
- Load byte, sign-extended: lb at 0x80000003 with dmem_rdata=0x00000000_80FF0000 -> dmem_addr=0x80000000, wmask=0; wb_result=0xFFFFFFFF_FFFFFF80.
- lhu at 0x80000006 with rdata=0xBEEF0000_00000000 -> wb_result=0x00000000_0000BEEF; lh with same data -> 0xFFFFFFFF_FFFFBEEF.
- sw at 0x80000004 with wdata=0x11223344 -> dmem_wmask=0xF0, dmem_wdata[63:32]=0x11223344, dmem_req_wen=1; wb_reg_wen=0.
- dmem_req_ready low for 3 cycles -> dmem_req_valid held high, addr/wdata stable, mem_allowin=0; WAIT entered only after ready.
- wb_allowin low while in DONE -> result held; mem_allowin=0; an ADD behind it is accepted in the cycle wb_allowin rises.
- Flush in WAIT, then resp after 2 cycles -> no mem_to_wb_valid; state returns IDLE. Separately, lw at 0x...2 -> no request, wb_misalign=1, wb_result=0.
